// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS core: opcodes, ALU encoding,
// FSM states and the decoded-control bundle produced from a latched instruction.
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_SLL   = 6'h00;
   localparam logic [5:0] FN_SRL   = 6'h02;
   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_AND   = 6'h24;
   localparam logic [5:0] FN_OR    = 6'h25;
   localparam logic [5:0] FN_SLT   = 6'h2A;

   localparam logic [4:0] LINK_REG = 5'd31;

   typedef enum logic [2:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_AND,
      ALU_OR,
      ALU_SLT,
      ALU_SLL,
      ALU_SRL
   } alu_op_t;

   typedef enum logic [2:0] {
      S_IF,
      S_ID,
      S_EX,
      S_MEM,
      S_WB,
      S_TRAP
   } state_t;

   typedef struct packed {
      logic    regdst;
      logic    alusrc;
      logic    memrd;
      logic    memwr;
      logic    branch;
      logic    bne;
      logic    jump;
      logic    jr;
      logic    link;
      logic    regwr;
      logic    shift;
      logic    illegal;
      alu_op_t alu_op;
   } ctrl_t;

   // Pure decode of one instruction word; anything unrecognised is flagged illegal
   // with every side-effecting control left deasserted.
   function automatic ctrl_t decode(input logic [31:0] ir);
      ctrl_t c;
      c        = '0;
      c.alu_op = ALU_ADD;
      case (ir[31:26])
         OP_RTYPE: begin
            c.regdst = 1'b1;
            c.regwr  = 1'b1;
            case (ir[5:0])
               FN_ADD:  c.alu_op = ALU_ADD;
               FN_SUB:  c.alu_op = ALU_SUB;
               FN_AND:  c.alu_op = ALU_AND;
               FN_OR:   c.alu_op = ALU_OR;
               FN_SLT:  c.alu_op = ALU_SLT;
               FN_SLL:  begin c.alu_op = ALU_SLL; c.shift = 1'b1; end
               FN_SRL:  begin c.alu_op = ALU_SRL; c.shift = 1'b1; end
               FN_JR:   begin c.jr = 1'b1; c.regwr = 1'b0; end
               default: begin c.illegal = 1'b1; c.regwr = 1'b0; c.regdst = 1'b0; end
            endcase
         end
         OP_ADDI: begin c.alusrc = 1'b1; c.regwr = 1'b1; end
         OP_LW:   begin c.alusrc = 1'b1; c.memrd = 1'b1; c.regwr = 1'b1; end
         OP_SW:   begin c.alusrc = 1'b1; c.memwr = 1'b1; end
         OP_BEQ:  c.branch = 1'b1;
         OP_BNE:  begin c.branch = 1'b1; c.bne = 1'b1; end
         OP_J:    c.jump = 1'b1;
         OP_JAL:  begin c.jump = 1'b1; c.link = 1'b1; c.regwr = 1'b1; end
         default: c.illegal = 1'b1;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/mips_regfile.sv
// 32x32 register file: two combinational read ports, one clocked write port,
// optional hardwired-zero $0, cleared by the asynchronous active-high reset.
module mips_regfile #(
   parameter bit ZERO_REG = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        we,
   input  logic [4:0]  waddr,
   input  logic [31:0] wdata,
   input  logic [4:0]  raddr1,
   input  logic [4:0]  raddr2,
   output logic [31:0] rdata1,
   output logic [31:0] rdata2
);

   logic [31:0] regs [32];
   logic        wr_allowed;

   assign wr_allowed = we && !(ZERO_REG && (waddr == 5'd0));

   // NOTE: this array is reset because every register must read 0 after reset;
   // a plain RAM would normally be left unreset so it can map onto memory macros.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         for (int i = 0; i < 32; i++) regs[i] <= '0;
      end else if (wr_allowed) begin
         regs[waddr] <= wdata;
      end
   end

   assign rdata1 = (ZERO_REG && (raddr1 == 5'd0)) ? '0 : regs[raddr1];
   assign rdata2 = (ZERO_REG && (raddr2 == 5'd0)) ? '0 : regs[raddr2];

endmodule

// File: rtl/multicycle_mips.sv
// Multi-cycle MIPS core: IF/ID/EX/MEM/WB FSM around one ALU, with req/ready
// handshakes to both memories. rst_n is an asynchronous, active-HIGH reset.
module multicycle_mips
   import mips_pkg::*;
#(
   parameter logic [31:0] PC_RESET = 32'h0,
   parameter int          DMEM_AW  = 7,
   parameter bit          ZERO_REG = 1'b1
) (
   input  logic               clk,
   input  logic               rst_n,
   output logic [31:0]        IR_addr,
   output logic               imem_req,
   input  logic               imem_ready,
   input  logic [31:0]        IR,
   output logic               CEN,
   output logic               WEN,
   output logic               OEN,
   output logic [DMEM_AW-1:0] A,
   output logic [31:0]        Data2Mem,
   input  logic [31:0]        ReadDataMem,
   input  logic               dmem_ready,
   output logic               retire,
   output logic               trap
);

   state_t      state, state_nxt;
   ctrl_t       ctrl;
   logic [31:0] pc_q, ir_q, a_q, b_q, alu_q, mdr_q;
   logic [31:0] rdata1, rdata2;
   logic [31:0] imm_sext, jump_target, branch_target;
   logic [31:0] alu_a, alu_b, alu_res;
   logic        branch_eq, rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;

   assign ctrl          = decode(ir_q);
   assign imm_sext      = {{16{ir_q[15]}}, ir_q[15:0]};
   // pc_q already holds PC+4 once the fetch completes, so both targets are PC+4 relative.
   assign jump_target   = {pc_q[31:28], ir_q[25:0], 2'b00};
   assign branch_target = pc_q + {imm_sext[29:0], 2'b00};
   assign branch_eq     = (a_q == b_q);

   mips_regfile #(.ZERO_REG(ZERO_REG)) u_regfile (
      .clk    (clk),
      .rst_n  (rst_n),
      .we     (rf_we),
      .waddr  (rf_waddr),
      .wdata  (rf_wdata),
      .raddr1 (ir_q[25:21]),
      .raddr2 (ir_q[20:16]),
      .rdata1 (rdata1),
      .rdata2 (rdata2)
   );

   assign rf_we    = (state == S_WB) && ctrl.regwr;
   assign rf_waddr = ctrl.link ? LINK_REG : (ctrl.regdst ? ir_q[15:11] : ir_q[20:16]);
   assign rf_wdata = ctrl.memrd ? mdr_q : alu_q;

   // Shifts move rt (held in b_q) by the zero-extended shamt field.
   always_comb begin
      alu_a   = ctrl.shift ? b_q : a_q;
      alu_b   = ctrl.shift ? {27'd0, ir_q[10:6]} : (ctrl.alusrc ? imm_sext : b_q);
      alu_res = '0;
      case (ctrl.alu_op)
         ALU_ADD: alu_res = alu_a + alu_b;
         ALU_SUB: alu_res = alu_a - alu_b;
         ALU_AND: alu_res = alu_a & alu_b;
         ALU_OR:  alu_res = alu_a | alu_b;
         ALU_SLT: alu_res = {31'd0, $signed(alu_a) < $signed(alu_b)};
         ALU_SLL: alu_res = alu_a << alu_b[4:0];
         ALU_SRL: alu_res = alu_a >> alu_b[4:0];
         default: alu_res = '0;
      endcase
   end

   // NOTE: clocked state is written with <= so every flop samples pre-edge values
   // regardless of block ordering.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) state <= S_IF;
      else       state <= state_nxt;
   end

   // NOTE: state_nxt gets a default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IF: begin
            if (imem_ready) state_nxt = S_ID;
         end
         S_ID: begin
            if (ctrl.illegal)                 state_nxt = S_TRAP;
            else if (ctrl.jump && !ctrl.link) state_nxt = S_IF;
            else                              state_nxt = S_EX;
         end
         S_EX: begin
            if (ctrl.branch || ctrl.jr)       state_nxt = S_IF;
            else if (ctrl.memrd || ctrl.memwr) state_nxt = S_MEM;
            else                              state_nxt = S_WB;
         end
         S_MEM: begin
            if (dmem_ready) state_nxt = ctrl.memrd ? S_WB : S_IF;
         end
         S_WB:    state_nxt = S_IF;
         S_TRAP:  state_nxt = S_TRAP;
         default: state_nxt = S_IF;
      endcase
   end

   // Outputs are gated by reset so a pending request drops the instant reset rises.
   always_comb begin
      imem_req = 1'b0;
      CEN      = 1'b1;
      WEN      = 1'b1;
      OEN      = 1'b1;
      retire   = 1'b0;
      trap     = 1'b0;
      if (!rst_n) begin
         case (state)
            S_IF:  imem_req = 1'b1;
            S_ID:  retire   = ctrl.jump && !ctrl.link;
            S_EX:  retire   = ctrl.branch || ctrl.jr;
            S_MEM: begin
               CEN    = 1'b0;
               WEN    = !ctrl.memwr;
               OEN    = !ctrl.memrd;
               retire = ctrl.memwr && dmem_ready;
            end
            S_WB:    retire = 1'b1;
            S_TRAP:  trap   = 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         pc_q  <= PC_RESET;
         ir_q  <= '0;
         a_q   <= '0;
         b_q   <= '0;
         alu_q <= '0;
         mdr_q <= '0;
      end else begin
         case (state)
            S_IF: begin
               if (imem_ready) begin
                  ir_q <= IR;
                  pc_q <= pc_q + 32'd4;
               end
            end
            S_ID: begin
               a_q <= rdata1;
               b_q <= rdata2;
               if (ctrl.jump && !ctrl.link) pc_q <= jump_target;
            end
            S_EX: begin
               // jal parks its return address (PC+4) here for the WB write to $31.
               alu_q <= ctrl.link ? pc_q : alu_res;
               if (ctrl.jr)                                        pc_q <= a_q;
               else if (ctrl.jump)                                 pc_q <= jump_target;
               else if (ctrl.branch && (branch_eq != ctrl.bne))    pc_q <= branch_target;
            end
            S_MEM: begin
               if (dmem_ready && ctrl.memrd) mdr_q <= ReadDataMem;
            end
            default: ;
         endcase
      end
   end

   assign IR_addr  = pc_q;
   assign A        = alu_q[DMEM_AW-1:0];
   assign Data2Mem = b_q;

endmodule

// File: tb/tb_multicycle_mips.sv
// Scoreboard bench for multicycle_mips: programs are loaded into an instruction
// ROM model, and observed fetches/stores are compared against queued expectations.
module tb_multicycle_mips;
   import mips_pkg::*;

   localparam int          AW  = 7;
   localparam logic [31:0] ILL = 32'hFC00_0000;

   typedef struct packed {
      logic [AW-1:0] a;
      logic [31:0]   d;
   } st_t;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   logic [31:0]   IR_addr, IR, Data2Mem, ReadDataMem;
   logic          imem_req, imem_ready, CEN, WEN, OEN, dmem_ready, retire, trap;
   logic [AW-1:0] A;
   logic [31:0]   IR_addr_z, IR_z, Data2Mem_z, ReadDataMem_z;
   logic          imem_req_z, imem_ready_z, CEN_z, WEN_z, OEN_z, dmem_ready_z, retire_z, trap_z;
   logic [AW-1:0] A_z;

   logic [31:0] imem   [0:255];
   logic [31:0] dmem   [0:(1<<AW)-1];
   logic [31:0] dmem_z [0:(1<<AW)-1];
   int dmem_wait = 0;
   int dcnt = 0;
   int cyc = 0;
   int n_cmp = 0;
   int n_fail = 0;

   logic [31:0] exp_fetch_q[$], obs_fetch_q[$];
   st_t         exp_st_q[$], obs_st_q[$], exp_st_z_q[$], obs_st_z_q[$];
   int          retire_cyc_q[$], retire_z_q[$];

   multicycle_mips #(.PC_RESET(32'h0), .DMEM_AW(AW), .ZERO_REG(1'b1)) u_dut (
      .clk(clk), .rst_n(rst_n), .IR_addr(IR_addr), .imem_req(imem_req), .imem_ready(imem_ready),
      .IR(IR), .CEN(CEN), .WEN(WEN), .OEN(OEN), .A(A), .Data2Mem(Data2Mem),
      .ReadDataMem(ReadDataMem), .dmem_ready(dmem_ready), .retire(retire), .trap(trap)
   );

   multicycle_mips #(.PC_RESET(32'h0), .DMEM_AW(AW), .ZERO_REG(1'b0)) u_dut_z0 (
      .clk(clk), .rst_n(rst_n), .IR_addr(IR_addr_z), .imem_req(imem_req_z), .imem_ready(imem_ready_z),
      .IR(IR_z), .CEN(CEN_z), .WEN(WEN_z), .OEN(OEN_z), .A(A_z), .Data2Mem(Data2Mem_z),
      .ReadDataMem(ReadDataMem_z), .dmem_ready(dmem_ready_z), .retire(retire_z), .trap(trap_z)
   );

   // Zero-wait instruction ROM; data memory with a programmable wait count.
   assign IR            = imem[IR_addr[9:2]];
   assign imem_ready    = imem_req;
   assign dmem_ready    = !CEN && (dcnt >= dmem_wait);
   assign ReadDataMem   = OEN ? 32'h0 : dmem[A];
   assign IR_z          = imem[IR_addr_z[9:2]];
   assign imem_ready_z  = imem_req_z;
   assign dmem_ready_z  = !CEN_z;
   assign ReadDataMem_z = OEN_z ? 32'h0 : dmem_z[A_z];

   always @(posedge clk or posedge rst_n) begin
      if (rst_n)    dcnt <= 0;
      else if (CEN) dcnt <= 0;
      else          dcnt <= dcnt + 1;
   end

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!CEN && !WEN && dmem_ready) dmem[A] <= Data2Mem;
      if (!CEN_z && !WEN_z)           dmem_z[A_z] <= Data2Mem_z;
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         if (imem_req && imem_ready)     obs_fetch_q.push_back(IR_addr);
         if (!CEN && !WEN && dmem_ready) obs_st_q.push_back(st_t'{a: A, d: Data2Mem});
         if (!CEN_z && !WEN_z)           obs_st_z_q.push_back(st_t'{a: A_z, d: Data2Mem_z});
         if (retire)                     retire_cyc_q.push_back(cyc);
         if (retire_z)                   retire_z_q.push_back(cyc);
      end
   end

   function automatic logic [31:0] r_i(input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] rd, input logic [4:0] sh,
                                       input logic [5:0] fn);
      return {OP_RTYPE, rs, rt, rd, sh, fn};
   endfunction

   function automatic logic [31:0] i_i(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [31:0] j_i(input logic [5:0] op, input logic [31:0] tgt);
      return {op, tgt[27:2]};
   endfunction

   // Holds reset, fills the ROM with illegal words and clears all queues.
   task automatic do_reset();
      rst_n = 1'b1;
      for (int i = 0; i < 256; i++) imem[i] = ILL;
      exp_fetch_q.delete(); obs_fetch_q.delete();
      exp_st_q.delete();    obs_st_q.delete();
      exp_st_z_q.delete();  obs_st_z_q.delete();
      retire_cyc_q.delete(); retire_z_q.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++;
      if ({imem_req, CEN, WEN, OEN, retire, trap} !== 6'b011100) begin
         n_fail++;
         $display("FAIL reset_outputs: got %b expected 011100", {imem_req, CEN, WEN, OEN, retire, trap});
      end
      n_cmp++;
      if (IR_addr !== 32'h0 || IR_addr_z !== 32'h0) begin
         n_fail++; $display("FAIL reset_pc: got %h/%h expected 0", IR_addr, IR_addr_z);
      end
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (imem_req !== 1'b1) begin
         n_fail++; $display("FAIL reset_first_fetch: imem_req %b expected 1", imem_req);
      end
      @(negedge clk);
   endtask

   task automatic test_arith();
      logic [31:0] ef, of;
      st_t es, os;
      int gap;
      do_reset();
      imem[0] = i_i(OP_ADDI, 5'd0, 5'd1, 16'd5);
      imem[1] = i_i(OP_ADDI, 5'd0, 5'd2, 16'hFFFD);
      imem[2] = r_i(5'd1, 5'd2, 5'd3, 5'd0, FN_ADD);
      imem[3] = i_i(OP_SW, 5'd0, 5'd3, 16'd0);
      imem[4] = r_i(5'd1, 5'd1, 5'd1, 5'd0, FN_ADD);
      imem[5] = i_i(OP_SW, 5'd0, 5'd1, 16'd4);
      imem[6] = j_i(OP_J, 32'h18);
      exp_fetch_q = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18, 32'h18};
      exp_st_q.push_back(st_t'{a: 7'd0, d: 32'd2});
      exp_st_q.push_back(st_t'{a: 7'd4, d: 32'd10});
      rst_n = 1'b0;
      repeat (40) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         gap = (retire_cyc_q.size() > i + 1) ? retire_cyc_q[i+1] - retire_cyc_q[i] : -1;
         n_cmp++;
         if (gap != 4) begin n_fail++; $display("FAIL arith_retire_gap%0d: got %0d expected 4", i, gap); end
      end
      while (exp_fetch_q.size() > 0) begin
         ef = exp_fetch_q.pop_front();
         of = (obs_fetch_q.size() > 0) ? obs_fetch_q.pop_front() : 32'hx;
         n_cmp++;
         if (of !== ef) begin n_fail++; $display("FAIL arith_fetch: got %h expected %h", of, ef); end
      end
      while (exp_st_q.size() > 0) begin
         es = exp_st_q.pop_front();
         os = (obs_st_q.size() > 0) ? obs_st_q.pop_front() : 'x;
         n_cmp++;
         if (os !== es) begin n_fail++; $display("FAIL arith_store: got A=%0d D=%h expected A=%0d D=%h", os.a, os.d, es.a, es.d); end
      end
   endtask

   task automatic test_alu();
      st_t es, os;
      do_reset();
      imem[0]  = i_i(OP_ADDI, 5'd0, 5'd1, 16'hFFFA);
      imem[1]  = i_i(OP_ADDI, 5'd0, 5'd2, 16'd3);
      imem[2]  = r_i(5'd1, 5'd2, 5'd3, 5'd0, FN_SUB);
      imem[3]  = r_i(5'd1, 5'd2, 5'd4, 5'd0, FN_SLT);
      imem[4]  = r_i(5'd2, 5'd1, 5'd5, 5'd0, FN_SLT);
      imem[5]  = r_i(5'd0, 5'd2, 5'd6, 5'd4, FN_SLL);
      imem[6]  = r_i(5'd0, 5'd1, 5'd7, 5'd28, FN_SRL);
      imem[7]  = r_i(5'd1, 5'd2, 5'd8, 5'd0, FN_AND);
      imem[8]  = r_i(5'd1, 5'd2, 5'd9, 5'd0, FN_OR);
      for (int i = 0; i < 7; i++) imem[9+i] = i_i(OP_SW, 5'd0, 5'(3 + i), 16'(i));
      imem[16] = j_i(OP_J, 32'h40);
      exp_st_q = '{st_t'{a: 7'd0, d: 32'hFFFF_FFF7}, st_t'{a: 7'd1, d: 32'd1},
                   st_t'{a: 7'd2, d: 32'd0},          st_t'{a: 7'd3, d: 32'h30},
                   st_t'{a: 7'd4, d: 32'hF},          st_t'{a: 7'd5, d: 32'd2},
                   st_t'{a: 7'd6, d: 32'hFFFF_FFFB}};
      rst_n = 1'b0;
      repeat (90) @(negedge clk);
      while (exp_st_q.size() > 0) begin
         es = exp_st_q.pop_front();
         os = (obs_st_q.size() > 0) ? obs_st_q.pop_front() : 'x;
         n_cmp++;
         if (os !== es) begin n_fail++; $display("FAIL alu_store: got A=%0d D=%h expected A=%0d D=%h", os.a, os.d, es.a, es.d); end
      end
   endtask

   task automatic test_zero_reg();
      st_t es, os;
      do_reset();
      imem[0] = i_i(OP_ADDI, 5'd0, 5'd0, 16'd7);
      imem[1] = r_i(5'd0, 5'd0, 5'd4, 5'd0, FN_ADD);
      imem[2] = i_i(OP_SW, 5'd0, 5'd4, 16'd0);
      imem[3] = i_i(OP_SW, 5'd0, 5'd0, 16'd4);
      imem[4] = j_i(OP_J, 32'h10);
      exp_st_q   = '{st_t'{a: 7'd0, d: 32'd0},  st_t'{a: 7'd4, d: 32'd0}};
      // With an ordinary $0 the base register is 7 too, shifting both addresses.
      exp_st_z_q = '{st_t'{a: 7'd7, d: 32'd14}, st_t'{a: 7'd11, d: 32'd7}};
      rst_n = 1'b0;
      repeat (30) @(negedge clk);
      while (exp_st_q.size() > 0) begin
         es = exp_st_q.pop_front();
         os = (obs_st_q.size() > 0) ? obs_st_q.pop_front() : 'x;
         n_cmp++;
         if (os !== es) begin n_fail++; $display("FAIL zero_reg_on: got A=%0d D=%h expected A=%0d D=%h", os.a, os.d, es.a, es.d); end
      end
      while (exp_st_z_q.size() > 0) begin
         es = exp_st_z_q.pop_front();
         os = (obs_st_z_q.size() > 0) ? obs_st_z_q.pop_front() : 'x;
         n_cmp++;
         if (os !== es) begin n_fail++; $display("FAIL zero_reg_off: got A=%0d D=%h expected A=%0d D=%h", os.a, os.d, es.a, es.d); end
      end
      n_cmp++;
      if (retire_z_q.size() != retire_cyc_q.size() || retire_cyc_q.size() == 0) begin
         n_fail++; $display("FAIL zero_reg_retires: got %0d vs %0d expected equal and nonzero", retire_z_q.size(), retire_cyc_q.size());
      end
   endtask

   task automatic test_mem_wait();
      st_t es, os;
      int k, cnt, bad;
      do_reset();
      dmem_wait = 3;
      imem[0] = i_i(OP_ADDI, 5'd0, 5'd1, 16'd5);
      imem[1] = i_i(OP_SW, 5'd0, 5'd1, 16'd4);
      imem[2] = i_i(OP_LW, 5'd0, 5'd5, 16'd4);
      imem[3] = i_i(OP_SW, 5'd0, 5'd5, 16'd8);
      imem[4] = j_i(OP_J, 32'h10);
      exp_st_q = '{st_t'{a: 7'd4, d: 32'd5}, st_t'{a: 7'd8, d: 32'd5}};
      rst_n = 1'b0;
      k = 0;
      while (CEN !== 1'b0 && k < 50) begin @(negedge clk); k++; end
      cnt = 0; bad = 0;
      while (CEN === 1'b0 && cnt < 20) begin
         if (WEN !== 1'b0 || OEN !== 1'b1 || A !== 7'd4 || Data2Mem !== 32'd5) bad++;
         cnt++;
         @(negedge clk);
      end
      n_cmp++;
      if (cnt != 4) begin n_fail++; $display("FAIL sw_wait_cycles: got %0d expected 4", cnt); end
      n_cmp++;
      if (bad != 0) begin n_fail++; $display("FAIL sw_wait_stable: %0d unstable cycles expected 0", bad); end
      k = 0;
      while (CEN !== 1'b0 && k < 50) begin @(negedge clk); k++; end
      n_cmp++;
      if ({CEN, WEN, OEN} !== 3'b010 || A !== 7'd4) begin
         n_fail++; $display("FAIL lw_strobes: got CEN/WEN/OEN=%b A=%0d expected 010 A=4", {CEN, WEN, OEN}, A);
      end
      repeat (30) @(negedge clk);
      while (exp_st_q.size() > 0) begin
         es = exp_st_q.pop_front();
         os = (obs_st_q.size() > 0) ? obs_st_q.pop_front() : 'x;
         n_cmp++;
         if (os !== es) begin n_fail++; $display("FAIL mem_store: got A=%0d D=%h expected A=%0d D=%h", os.a, os.d, es.a, es.d); end
      end
      dmem_wait = 0;
   endtask

   task automatic test_branch();
      logic [31:0] ef, of;
      do_reset();
      imem[0]  = i_i(OP_ADDI, 5'd0, 5'd1, 16'd1);
      imem[1]  = i_i(OP_ADDI, 5'd0, 5'd2, 16'd1);
      imem[2]  = j_i(OP_J, 32'h10);
      imem[3]  = j_i(OP_J, 32'h18);
      imem[4]  = i_i(OP_BEQ, 5'd1, 5'd2, 16'hFFFE);
      imem[6]  = i_i(OP_BNE, 5'd1, 5'd2, 16'd5);
      imem[7]  = i_i(OP_ADDI, 5'd0, 5'd3, 16'd2);
      imem[8]  = i_i(OP_BNE, 5'd1, 5'd3, 16'd2);
      imem[9]  = j_i(OP_J, 32'h24);
      imem[11] = j_i(OP_J, 32'h2C);
      exp_fetch_q = '{32'h00, 32'h04, 32'h08, 32'h10, 32'h0C, 32'h18,
                      32'h1C, 32'h20, 32'h2C, 32'h2C};
      rst_n = 1'b0;
      repeat (45) @(negedge clk);
      while (exp_fetch_q.size() > 0) begin
         ef = exp_fetch_q.pop_front();
         of = (obs_fetch_q.size() > 0) ? obs_fetch_q.pop_front() : 32'hx;
         n_cmp++;
         if (of !== ef) begin n_fail++; $display("FAIL branch_fetch: got %h expected %h", of, ef); end
      end
   endtask

   task automatic test_jal_jr();
      logic [31:0] ef, of;
      st_t es, os;
      do_reset();
      imem[0]  = j_i(OP_J, 32'h20);
      imem[8]  = j_i(OP_JAL, 32'h40);
      imem[9]  = i_i(OP_SW, 5'd0, 5'd31, 16'd0);
      imem[10] = j_i(OP_J, 32'h28);
      imem[16] = r_i(5'd31, 5'd0, 5'd0, 5'd0, FN_JR);
      exp_fetch_q = '{32'h00, 32'h20, 32'h40, 32'h24, 32'h28, 32'h28};
      exp_st_q.push_back(st_t'{a: 7'd0, d: 32'h24});
      rst_n = 1'b0;
      repeat (30) @(negedge clk);
      while (exp_fetch_q.size() > 0) begin
         ef = exp_fetch_q.pop_front();
         of = (obs_fetch_q.size() > 0) ? obs_fetch_q.pop_front() : 32'hx;
         n_cmp++;
         if (of !== ef) begin n_fail++; $display("FAIL jal_fetch: got %h expected %h", of, ef); end
      end
      while (exp_st_q.size() > 0) begin
         es = exp_st_q.pop_front();
         os = (obs_st_q.size() > 0) ? obs_st_q.pop_front() : 'x;
         n_cmp++;
         if (os !== es) begin n_fail++; $display("FAIL jal_link: got A=%0d D=%h expected A=%0d D=%h", os.a, os.d, es.a, es.d); end
      end
   endtask

   task automatic test_trap();
      int bad;
      do_reset();
      rst_n = 1'b0;
      repeat (4) @(negedge clk);
      n_cmp++;
      if (trap !== 1'b1 || trap_z !== 1'b1) begin n_fail++; $display("FAIL trap_opcode: got %b/%b expected 1/1", trap, trap_z); end
      bad = 0;
      repeat (10) begin
         @(negedge clk);
         if (imem_req !== 1'b0 || retire !== 1'b0 || CEN !== 1'b1 || trap !== 1'b1) bad++;
      end
      n_cmp++;
      if (bad != 0) begin n_fail++; $display("FAIL trap_halted: %0d active cycles expected 0", bad); end
      n_cmp++;
      if (obs_fetch_q.size() != 1) begin n_fail++; $display("FAIL trap_fetches: got %0d expected 1", obs_fetch_q.size()); end
      do_reset();
      imem[0] = r_i(5'd1, 5'd2, 5'd3, 5'd0, 6'h3F);
      rst_n = 1'b0;
      repeat (4) @(negedge clk);
      n_cmp++;
      if (trap !== 1'b1) begin n_fail++; $display("FAIL trap_funct: got %b expected 1", trap); end
   endtask

   task automatic test_reset_mid_mem();
      int k;
      do_reset();
      dmem_wait = 10;
      imem[0] = i_i(OP_SW, 5'd0, 5'd0, 16'd3);
      rst_n = 1'b0;
      k = 0;
      while (CEN !== 1'b0 && k < 20) begin @(negedge clk); k++; end
      n_cmp++;
      if (CEN !== 1'b0) begin n_fail++; $display("FAIL mid_mem_reach: CEN %b expected 0", CEN); end
      @(negedge clk);
      #2 rst_n = 1'b1;
      #1;
      n_cmp++;
      if ({CEN, WEN, OEN, imem_req} !== 4'b1110) begin
         n_fail++; $display("FAIL mid_mem_drop: got CEN/WEN/OEN/req=%b expected 1110", {CEN, WEN, OEN, imem_req});
      end
      n_cmp++;
      if (IR_addr !== 32'h0) begin n_fail++; $display("FAIL mid_mem_pc: got %h expected 0", IR_addr); end
      repeat (3) @(negedge clk);
      n_cmp++;
      if (obs_st_q.size() != 0) begin n_fail++; $display("FAIL mid_mem_nostore: got %0d stores expected 0", obs_st_q.size()); end
      dmem_wait = 0;
   endtask

   initial begin
      test_reset();
      test_arith();
      test_alu();
      test_zero_reg();
      test_mem_wait();
      test_branch();
      test_jal_jr();
      test_trap();
      test_reset_mid_mem();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
